// File: rtl/msrv32_rf_wr_arbiter.sv
// rtl/msrv32_rf_wr_arbiter.sv - register-file write-port arbiter between pipeline writeback and multi-cycle unit
//
// The pipeline always wins the single write port. A multi-cycle (mc) result
// that loses is parked in a one-entry buffer. That buffer is written when the
// pipeline leaves the port free. It is discarded if the pipeline overwrites
// the same rd first. If the pipeline keeps the port busy for STARVE_LIMIT
// writes, the arbiter stalls the pipeline for one cycle to drain the buffer.
//
// Ports:
//   ms_riscv32_mp_clk_in    clock, rising edge
//   ms_riscv32_mp_rst_n_in  synchronous active-low reset
//   wb_wr_en_in/wb_rd_addr_in/wb_data_in   pipeline writeback request
//   mc_valid_in/mc_rd_addr_in/mc_data_in   multi-cycle result; mc_ready_out accepts it
//   rf_wr_en_out/rf_rd_addr_out/rf_wr_data_out  registered register-file write
//   stall_out               pipeline freeze, decoded from state (DRAIN)
//   stall_cnt_out           DRAIN entry count, saturating (only with RF_ARB_PERF_EN)
//
// Optional build macro: RF_ARB_PERF_EN adds the stall_cnt_out counter.

module msrv32_rf_wr_arbiter #(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        ms_riscv32_mp_clk_in,
    input  logic        ms_riscv32_mp_rst_n_in,
    input  logic        wb_wr_en_in,
    input  logic [4:0]  wb_rd_addr_in,
    input  logic [31:0] wb_data_in,
    input  logic        mc_valid_in,
    input  logic [4:0]  mc_rd_addr_in,
    input  logic [31:0] mc_data_in,
    output logic        mc_ready_out,
    output logic        rf_wr_en_out,
    output logic [4:0]  rf_rd_addr_out,
    output logic [31:0] rf_wr_data_out,
`ifdef RF_ARB_PERF_EN
    output logic [15:0] stall_cnt_out,
`endif
    output logic        stall_out
);

    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HELD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  buf_rd_q, buf_rd_d;
    logic [31:0] buf_data_q, buf_data_d;
    logic [3:0]  age_q, age_d;
    logic        wr_en_q, wr_en_d;
    logic [4:0]  wr_rd_q, wr_rd_d;
    logic [31:0] wr_data_q, wr_data_d;

    // Requests to x0 are null: they never occupy the port.
    logic wb_hit;
    logic mc_hit;
    assign wb_hit = wb_wr_en_in && (wb_rd_addr_in != 5'd0);
    assign mc_hit = mc_valid_in && mc_ready_out && (mc_rd_addr_in != 5'd0);

    assign mc_ready_out = (state_q == IDLE);
    assign stall_out    = (state_q == DRAIN);

    always_comb begin
        state_d    = state_q;
        buf_rd_d   = buf_rd_q;
        buf_data_d = buf_data_q;
        age_d      = age_q;
        wr_en_d    = 1'b0;
        wr_rd_d    = wr_rd_q;
        wr_data_d  = wr_data_q;

        unique case (state_q)
            IDLE: begin
                if (wb_hit) begin
                    wr_en_d   = 1'b1;
                    wr_rd_d   = wb_rd_addr_in;
                    wr_data_d = wb_data_in;
                    if (mc_hit) begin
                        buf_rd_d   = mc_rd_addr_in;
                        buf_data_d = mc_data_in;
                        age_d      = 4'd0;
                        state_d    = HELD;
                    end
                end else if (mc_hit) begin
                    wr_en_d   = 1'b1;
                    wr_rd_d   = mc_rd_addr_in;
                    wr_data_d = mc_data_in;
                end
            end
            HELD: begin
                if (!wb_hit) begin
                    wr_en_d   = 1'b1;
                    wr_rd_d   = buf_rd_q;
                    wr_data_d = buf_data_q;
                    state_d   = IDLE;
                end else begin
                    wr_en_d   = 1'b1;
                    wr_rd_d   = wb_rd_addr_in;
                    wr_data_d = wb_data_in;
                    if (wb_rd_addr_in == buf_rd_q) begin
                        // Pipeline value is younger; the buffered one is dead.
                        state_d = IDLE;
                    end else begin
                        age_d = age_q + 4'd1;
                        if (age_d == LIMIT) begin
                            state_d = DRAIN;
                        end
                    end
                end
            end
            DRAIN: begin
                // The pipeline is frozen; its request is re-presented next cycle.
                wr_en_d   = 1'b1;
                wr_rd_d   = buf_rd_q;
                wr_data_d = buf_data_q;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            state_q    <= IDLE;
            buf_rd_q   <= 5'd0;
            buf_data_q <= 32'd0;
            age_q      <= 4'd0;
            wr_en_q    <= 1'b0;
            wr_rd_q    <= 5'd0;
            wr_data_q  <= 32'd0;
        end else begin
            state_q    <= state_d;
            buf_rd_q   <= buf_rd_d;
            buf_data_q <= buf_data_d;
            age_q      <= age_d;
            wr_en_q    <= wr_en_d;
            wr_rd_q    <= wr_rd_d;
            wr_data_q  <= wr_data_d;
        end
    end

    assign rf_wr_en_out   = wr_en_q;
    assign rf_rd_addr_out = wr_rd_q;
    assign rf_wr_data_out = wr_data_q;

`ifdef RF_ARB_PERF_EN
    logic [15:0] stall_cnt_q;

    always_ff @(posedge ms_riscv32_mp_clk_in) begin
        if (!ms_riscv32_mp_rst_n_in) begin
            stall_cnt_q <= 16'd0;
        end else if ((state_q == HELD) && (state_d == DRAIN) && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_q <= stall_cnt_q + 16'd1;
        end
    end

    assign stall_cnt_out = stall_cnt_q;
`endif

endmodule

// File: doc/msrv32_rf_wr_arbiter.md
MSRV32_RF_WR_ARBITER -- requirements
Module: msrv32_rf_wr_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max pipeline-blocked cycles before a buffered result forces a stall; legal range 1..15.
REQ-002 ms_riscv32_mp_clk_in  input  1  sole clock, rising edge.
REQ-003 ms_riscv32_mp_rst_n_in  input  1  reset, synchronous, active-low.
REQ-004 wb_wr_en_in  input  1  pipeline writeback request.
REQ-005 wb_rd_addr_in  input  5  pipeline destination register.
REQ-006 wb_data_in  input  32  pipeline writeback data (writeback mux output).
REQ-007 mc_valid_in  input  1  multi-cycle unit result valid.
REQ-008 mc_rd_addr_in  input  5  multi-cycle result destination register.
REQ-009 mc_data_in  input  32  multi-cycle result data.
REQ-010 mc_ready_out  output  1  arbiter accepts an mc result this cycle.
REQ-011 rf_wr_en_out  output  1  register-file write enable, registered.
REQ-012 rf_rd_addr_out  output  5  register-file write address, registered.
REQ-013 rf_wr_data_out  output  32  register-file write data, registered.
REQ-014 stall_out  output  1  freeze pipeline this cycle, decoded from state.

Function
REQ-015 The block SHALL share the single register-file write port between the pipeline and the multi-cycle unit, pipeline having fixed priority, through a one-entry holding buffer.
REQ-016 A request to rd 0 SHALL be "null": never written, never counted as port use.
REQ-017 The winning write SHALL appear on rf_* outputs exactly one cycle after its request; rf_wr_en_out SHALL be 0 in any cycle following no winning write.
REQ-018 States: IDLE (buffer empty), HELD (buffer full), DRAIN (forced drain).
REQ-019 mc_ready_out SHALL be 1 in IDLE, 0 in HELD and DRAIN; an mc transfer occurs when mc_valid_in and mc_ready_out are both 1.
REQ-020 IDLE, mc transfer, no non-null pipeline write: mc result written directly; stay IDLE.
REQ-021 IDLE, mc transfer plus non-null pipeline write: pipeline written, mc result captured into buffer, age counter cleared, go HELD.
REQ-022 HELD, no non-null pipeline write: buffer written, go IDLE.
REQ-023 HELD, non-null pipeline write with rd equal to buffered rd: pipeline written, buffer discarded unwritten (older value), go IDLE.
REQ-024 HELD, other non-null pipeline write: pipeline written, age increments; when age reaches STARVE_LIMIT go DRAIN.
REQ-025 DRAIN: stall_out=1, pipeline inputs ignored, buffer written, go IDLE next cycle; pipeline re-presents its request after the stall.
REQ-026 stall_out SHALL be 0 in IDLE and HELD.
REQ-027 Age counter SHALL be 4 bits, cleared on every buffer capture, never wraps (DRAIN entered first).

Reset
REQ-028 While ms_riscv32_mp_rst_n_in is low at a clock edge: state IDLE, buffer invalid, age 0, rf_wr_en_out 0, rf_rd_addr_out 0, rf_wr_data_out 0; stall_out 0 and mc_ready_out 1 in the following cycle.
REQ-029 Reset asserted in HELD or DRAIN SHALL discard the buffered result without writing it.

Configuration
REQ-030 Macro RF_ARB_PERF_EN defined: adds output stall_cnt_out (16 bits), counting DRAIN entries, saturating at 16'hFFFF, reset to 0.
REQ-031 Macro undefined: no stall_cnt_out port, no counter logic; all other behaviour identical.

Verification
REQ-032 mc_valid=1 rd=5 data=32'h11, wb_wr_en=0 -> next cycle rf_wr_en=1, addr=5, data=32'h11, state IDLE.
REQ-033 Same cycle wb rd=3 data=32'hA, mc rd=7 data=32'hB -> cycle+1 writes x3=A; cycle+2 (pipeline idle) writes x7=B; mc_ready low one cycle.
REQ-034 Buffer x7 held, pipeline writes x7=32'hC -> x7=C written, buffer dropped, no later write to x7.
REQ-035 STARVE_LIMIT=4, buffer held, pipeline writes x1..x4 back-to-back -> stall_out=1 in next cycle, buffered result written following cycle, mc_ready returns 1.
REQ-036 Reset low while in HELD -> next cycle rf_wr_en=0, mc_ready=1, buffered result never written; with RF_ARB_PERF_EN, stall_cnt_out=0.
